riscv_crypto_fu_ssha_pipe: RTL

//  Pipelined SHA-2 function unit for the crypto coprocessor: all Zknh sigma/sum ops (SHA-256, RV32 split SHA-512,
//  RV64 SHA-512) behind a valid/ready handshake. XLEN-generic, LATENCY 1 or 2 register stages, flushable from the core.

---
 rtl/riscv_crypto_fu_ssha_pipe.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_crypto_fu_ssha_pipe.sv
// riscv_crypto_fu_ssha_pipe
//   Pipelined SHA-2 sigma/sum function unit (Zknh) with valid/ready handshakes.
//   Covers the SHA-256 ops for any XLEN, the split RV32 SHA-512 ops for XLEN=32 and
//   the full-width SHA-512 ops for XLEN=64. LATENCY selects one stage (result reg)
//   or two stages (operand reg + result reg). Ops that are illegal for the configured
//   XLEN still flow through the pipe and retire with rd=0 and out_err=1.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   flush      synchronous kill of every in-flight op; blocks acceptance this cycle
//   in_valid   an op is presented
//   in_ready   the unit takes the presented op this cycle
//   in_op      4-bit opcode
//   rs1, rs2   source operands (rs2 is read only by the split RV32 SHA-512 ops)
//   out_valid  a result is held in the last stage
//   out_ready  the consumer takes the held result this cycle
//   rd         result, meaningful while out_valid=1
//   out_err    the held op was illegal for this XLEN
module riscv_crypto_fu_ssha_pipe #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            out_err
);

    typedef enum logic [3:0] {
        OP_S256SIG0 = 4'd0,
        OP_S256SIG1 = 4'd1,
        OP_S256SUM0 = 4'd2,
        OP_S256SUM1 = 4'd3,
        OP_SUM0R    = 4'd4,
        OP_SUM1R    = 4'd5,
        OP_SIG0L    = 4'd6,
        OP_SIG0H    = 4'd7,
        OP_SIG1L    = 4'd8,
        OP_SIG1H    = 4'd9,
        OP_S512SIG0 = 4'd10,
        OP_S512SIG1 = 4'd11,
        OP_S512SUM0 = 4'd12,
        OP_S512SUM1 = 4'd13
    } op_e;

    localparam bit IS_RV32 = (XLEN == 32);

    function automatic logic [31:0] ror32(input logic [31:0] v, input int unsigned n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Operands feeding the compute logic: straight from the ports for LATENCY=1,
    // from the operand stage for LATENCY=2.
    logic [3:0]      c_op;
    logic [XLEN-1:0] c_rs1;
    logic [XLEN-1:0] c_rs2;

    logic [31:0]     x;
    logic [31:0]     b;
    logic [63:0]     y;
    logic [63:0]     res64;
    logic            is_rv32_op;
    logic            is_rv64_op;
    logic            c_err;
    logic [XLEN-1:0] c_rd;
    logic            unused_bits;

    assign x = c_rs1[31:0];
    assign b = c_rs2[31:0];
    assign y = 64'(c_rs1);

    // Upper rs2 bits (XLEN=64) and upper result bits (XLEN=32) are never read.
    assign unused_bits = ^{c_rs2, res64};

    always_comb begin
        // NOTE: default first so every path assigns res64 and no latch is inferred.
        res64 = '0;
        case (c_op)
            OP_S256SIG0: res64 = sext32(ror32(x, 7)  ^ ror32(x, 18) ^ (x >> 3));
            OP_S256SIG1: res64 = sext32(ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10));
            OP_S256SUM0: res64 = sext32(ror32(x, 2)  ^ ror32(x, 13) ^ ror32(x, 22));
            OP_S256SUM1: res64 = sext32(ror32(x, 6)  ^ ror32(x, 11) ^ ror32(x, 25));
            // Split SHA-512 ops: x is the low/high half a, b the other half.
            OP_SUM0R: res64 = {32'h0, (x << 25) ^ (x << 30) ^ (x >> 28)
                                     ^ (b >> 7) ^ (b >> 2) ^ (b << 4)};
            OP_SUM1R: res64 = {32'h0, (x << 23) ^ (x >> 14) ^ (x >> 18)
                                     ^ (b >> 9) ^ (b << 18) ^ (b << 14)};
            OP_SIG0L: res64 = {32'h0, (x >> 1) ^ (x >> 7) ^ (x >> 8)
                                     ^ (b << 31) ^ (b << 25) ^ (b << 24)};
            OP_SIG0H: res64 = {32'h0, (x >> 1) ^ (x >> 7) ^ (x >> 8)
                                     ^ (b << 31) ^ (b << 24)};
            OP_SIG1L: res64 = {32'h0, (x << 3) ^ (x >> 6) ^ (x >> 19)
                                     ^ (b >> 29) ^ (b << 26) ^ (b << 13)};
            OP_SIG1H: res64 = {32'h0, (x << 3) ^ (x >> 6) ^ (x >> 19)
                                     ^ (b >> 29) ^ (b << 13)};
            OP_S512SIG0: res64 = ror64(y, 1)  ^ ror64(y, 8)  ^ (y >> 7);
            OP_S512SIG1: res64 = ror64(y, 19) ^ ror64(y, 61) ^ (y >> 6);
            OP_S512SUM0: res64 = ror64(y, 28) ^ ror64(y, 34) ^ ror64(y, 39);
            OP_S512SUM1: res64 = ror64(y, 14) ^ ror64(y, 18) ^ ror64(y, 41);
            default:     res64 = '0;
        endcase
    end

    assign is_rv32_op = (c_op >= 4'd4)  && (c_op <= 4'd9);
    assign is_rv64_op = (c_op >= 4'd10) && (c_op <= 4'd13);
    assign c_err      = (c_op >= 4'd14) || (is_rv32_op && !IS_RV32) || (is_rv64_op && IS_RV32);
    // Truncation to 32 bits also drops the SHA-256 sign extension when XLEN=32.
    assign c_rd       = c_err ? '0 : res64[XLEN-1:0];

    generate
        if (LATENCY == 1) begin : g_lat1
            assign c_op  = in_op;
            assign c_rs1 = rs1;
            assign c_rs2 = rs2;

            // The only stage may load when empty or when its result retires.
            assign in_ready = !flush && (!out_valid || out_ready);

            // NOTE: sequential state uses non-blocking assignments only.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    rd        <= '0;
                    out_err   <= 1'b0;
                end else if (flush) begin
                    out_valid <= 1'b0;
                end else if (!out_valid || out_ready) begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        rd      <= c_rd;
                        out_err <= c_err;
                    end
                end
            end
        end else begin : g_lat2
            logic            s1_valid;
            logic [3:0]      s1_op;
            logic [XLEN-1:0] s1_rs1;
            logic [XLEN-1:0] s1_rs2;
            logic            s2_open;

            assign c_op  = s1_op;
            assign c_rs1 = s1_rs1;
            assign c_rs2 = s1_rs2;

            // Result stage can take new contents when empty or retiring; the operand
            // stage can then load when empty or when it moves into the result stage.
            assign s2_open  = !out_valid || out_ready;
            assign in_ready = !flush && (!s1_valid || s2_open);

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid  <= 1'b0;
                    out_valid <= 1'b0;
                    rd        <= '0;
                    out_err   <= 1'b0;
                end else if (flush) begin
                    s1_valid  <= 1'b0;
                    out_valid <= 1'b0;
                end else begin
                    if (s2_open) begin
                        out_valid <= s1_valid;
                        if (s1_valid) begin
                            rd      <= c_rd;
                            out_err <= c_err;
                        end
                    end
                    if (!s1_valid || s2_open) begin
                        s1_valid <= in_valid;
                    end
                end
            end

            // NOTE: operand payload has no reset; it is only read behind s1_valid.
            always_ff @(posedge clk) begin
                if (in_valid && in_ready) begin
                    s1_op  <= in_op;
                    s1_rs1 <= rs1;
                    s1_rs2 <= rs2;
                end
            end
        end
    endgenerate

endmodule
